// File: rtl/gomoku_pkg.sv
// Shared definitions for the Gomoku board controller: cell and winner
// encodings, board size defaults, the scan direction table and FSM states.
package gomoku_pkg;

    localparam int BOARD_N_DEF = 15;
    localparam int WIN_LEN_DEF = 5;

    // Cell contents as stored on the board and returned on the read port.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Game result encoding.
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_BLACK = 2'b01;
    localparam logic [1:0] WIN_WHITE = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    // Top-level control states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DONE
    } ctrl_state_t;

    // Win checker states.
    typedef enum logic {
        CK_IDLE,
        CK_SCAN
    } chk_state_t;

    // Per-axis step applied while walking away from the placed stone.
    typedef enum logic [1:0] {
        D_ZERO,
        D_POS,
        D_NEG
    } delta_t;

    // Direction table: 0=(0,+1) 1=(+1,0) 2=(+1,+1) 3=(+1,-1), as (row,col).
    function automatic delta_t dir_row_delta(input logic [1:0] dir);
        if (dir == 2'd0) return D_ZERO;
        return D_POS;
    endfunction

    function automatic delta_t dir_col_delta(input logic [1:0] dir);
        case (dir)
            2'd0:    return D_POS;
            2'd1:    return D_ZERO;
            2'd2:    return D_POS;
            default: return D_NEG;
        endcase
    endfunction

    // The minus sense walks the same line the other way.
    function automatic delta_t flip_delta(input delta_t d);
        case (d)
            D_POS:   return D_NEG;
            D_NEG:   return D_POS;
            default: return D_ZERO;
        endcase
    endfunction

    // True when stepping v by d would leave the board.
    function automatic logic at_edge(input logic [3:0] v, input delta_t d,
                                     input logic [3:0] max_idx);
        case (d)
            D_POS:   return v == max_idx;
            D_NEG:   return v == 4'd0;
            default: return 1'b0;
        endcase
    endfunction

    // Coordinate after one step; only used once at_edge has been ruled out.
    function automatic logic [3:0] step_coord(input logic [3:0] v, input delta_t d);
        case (d)
            D_POS:   return v + 4'd1;
            D_NEG:   return v - 4'd1;
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/gomoku_win_checker.sv
// Five-in-a-row detector. On start it latches the placed stone and walks the
// four lines through it, reading one board cell per cycle, and pulses done
// (with win) as soon as a long enough run is seen or all lines are exhausted.
module gomoku_win_checker
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = BOARD_N_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] place_row,
    input  logic [3:0] place_col,
    input  logic [1:0] colour,
    output logic [3:0] scan_row,
    output logic [3:0] scan_col,
    input  logic [1:0] scan_cell,
    output logic       done,
    output logic       win
);

    localparam logic [3:0] MAX_IDX   = 4'(BOARD_N - 1);
    localparam logic [3:0] MAX_STEPS = 4'(WIN_LEN - 1);
    localparam logic [4:0] WIN_RUN   = 5'(WIN_LEN);

    chk_state_t state_reg, state_next;
    logic [3:0] org_row_reg, org_row_next;
    logic [3:0] org_col_reg, org_col_next;
    logic [3:0] cur_row_reg, cur_row_next;
    logic [3:0] cur_col_reg, cur_col_next;
    logic [1:0] colour_reg, colour_next;
    logic [1:0] dir_reg, dir_next;
    logic       sense_reg, sense_next;
    logic [3:0] steps_reg, steps_next;
    logic [4:0] run_reg, run_next;
    logic       done_reg, done_next;
    logic       win_reg, win_next;

    delta_t     row_delta, col_delta;
    logic       blocked;
    logic       match;
    logic       end_sense;
    logic [3:0] nxt_row, nxt_col;
    logic [4:0] run_inc;
    logic [3:0] steps_inc;

    // Scan step: pick the neighbour in the current direction/sense, compare it
    // and advance the walk, the direction, or finish.
    always_comb begin
        state_next   = state_reg;
        org_row_next = org_row_reg;
        org_col_next = org_col_reg;
        cur_row_next = cur_row_reg;
        cur_col_next = cur_col_reg;
        colour_next  = colour_reg;
        dir_next     = dir_reg;
        sense_next   = sense_reg;
        steps_next   = steps_reg;
        run_next     = run_reg;
        done_next    = 1'b0;
        win_next     = 1'b0;
        end_sense    = 1'b0;

        row_delta = dir_row_delta(dir_reg);
        col_delta = dir_col_delta(dir_reg);
        if (sense_reg) begin
            row_delta = flip_delta(row_delta);
            col_delta = flip_delta(col_delta);
        end

        // Edge test comes first so the scan address never leaves the board.
        blocked   = at_edge(cur_row_reg, row_delta, MAX_IDX) ||
                    at_edge(cur_col_reg, col_delta, MAX_IDX);
        nxt_row   = blocked ? cur_row_reg : step_coord(cur_row_reg, row_delta);
        nxt_col   = blocked ? cur_col_reg : step_coord(cur_col_reg, col_delta);
        match     = !blocked && (scan_cell == colour_reg);
        run_inc   = run_reg + 5'd1;
        steps_inc = steps_reg + 4'd1;

        case (state_reg)
            CK_IDLE: begin
                if (start) begin
                    org_row_next = place_row;
                    org_col_next = place_col;
                    cur_row_next = place_row;
                    cur_col_next = place_col;
                    colour_next  = colour;
                    dir_next     = 2'd0;
                    sense_next   = 1'b0;
                    steps_next   = 4'd0;
                    run_next     = 5'd1;
                    state_next   = CK_SCAN;
                end
            end
            CK_SCAN: begin
                if (match) begin
                    run_next     = run_inc;
                    steps_next   = steps_inc;
                    cur_row_next = nxt_row;
                    cur_col_next = nxt_col;
                    if (run_inc >= WIN_RUN) begin
                        done_next  = 1'b1;
                        win_next   = 1'b1;
                        state_next = CK_IDLE;
                    end else if (steps_inc >= MAX_STEPS) begin
                        end_sense = 1'b1;
                    end
                end else begin
                    end_sense = 1'b1;
                end

                if (end_sense) begin
                    cur_row_next = org_row_reg;
                    cur_col_next = org_col_reg;
                    steps_next   = 4'd0;
                    if (!sense_reg) begin
                        sense_next = 1'b1;
                    end else if (dir_reg == 2'd3) begin
                        done_next  = 1'b1;
                        state_next = CK_IDLE;
                    end else begin
                        dir_next   = dir_reg + 2'd1;
                        sense_next = 1'b0;
                        run_next   = 5'd1;
                    end
                end
            end
            default: state_next = CK_IDLE;
        endcase
    end

    // State register; reset aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CK_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Scan datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            org_row_reg <= 4'd0;
            org_col_reg <= 4'd0;
            cur_row_reg <= 4'd0;
            cur_col_reg <= 4'd0;
            colour_reg  <= CELL_EMPTY;
            dir_reg     <= 2'd0;
            sense_reg   <= 1'b0;
            steps_reg   <= 4'd0;
            run_reg     <= 5'd0;
            done_reg    <= 1'b0;
            win_reg     <= 1'b0;
        end else begin
            org_row_reg <= org_row_next;
            org_col_reg <= org_col_next;
            cur_row_reg <= cur_row_next;
            cur_col_reg <= cur_col_next;
            colour_reg  <= colour_next;
            dir_reg     <= dir_next;
            sense_reg   <= sense_next;
            steps_reg   <= steps_next;
            run_reg     <= run_next;
            done_reg    <= done_next;
            win_reg     <= win_next;
        end
    end

    assign scan_row = nxt_row;
    assign scan_col = nxt_col;
    assign done     = done_reg;
    assign win      = win_reg;

endmodule

// File: rtl/gomoku_board_ctrl.sv
// Gomoku board controller: board storage, cursor, turn and game result.
// The renderer reads cells through a registered read port that is serviced
// every cycle; the win checker uses its own combinational scan port.
module gomoku_board_ctrl
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = BOARD_N_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output logic [1:0] rd_cell,
    output logic [3:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       cur_player,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] move_count
);

    localparam int         N_CELLS    = BOARD_N * BOARD_N;
    localparam logic [3:0] MAX_IDX    = 4'(BOARD_N - 1);
    localparam logic [3:0] CENTER     = 4'(BOARD_N / 2);
    localparam logic [7:0] FULL_COUNT = 8'(N_CELLS);

    // Row-major linear cell index.
    function automatic logic [7:0] cell_index(input logic [3:0] r, input logic [3:0] c);
        return 8'(r) * 8'(BOARD_N) + 8'(c);
    endfunction

    ctrl_state_t state_reg, state_next;
    logic [3:0]  cursor_row_reg, cursor_row_next;
    logic [3:0]  cursor_col_reg, cursor_col_next;
    logic        player_reg, player_next;
    logic [7:0]  move_count_reg, move_count_next;
    logic        game_over_reg, game_over_next;
    logic [1:0]  winner_reg, winner_next;
    logic        win_hit_reg, win_hit_next;
    logic [1:0]  rd_cell_reg;

    logic [2*N_CELLS-1:0] board_bits;
    logic                 wr_en;
    logic [7:0]           wr_idx;
    logic [1:0]           wr_val;

    logic [7:0] cursor_idx;
    logic [1:0] cursor_cell;
    logic [7:0] rd_idx;
    logic       rd_in_range;
    logic [3:0] scan_row, scan_col;
    logic [7:0] scan_idx;
    logic [1:0] scan_cell;
    logic [1:0] placer_colour;
    logic       accept;
    logic       chk_start;
    logic       chk_done;
    logic       chk_win;

    // Board cells live in flops so reset can clear the whole board at once.
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        logic [1:0] cell_reg;

        // One cell: cleared on reset, written only by an accepted placement.
        always_ff @(posedge clk) begin
            if (rst) begin
                cell_reg <= CELL_EMPTY;
            end else if (wr_en && (wr_idx == 8'(gi))) begin
                cell_reg <= wr_val;
            end
        end

        assign board_bits[2*gi +: 2] = cell_reg;
    end

    assign cursor_idx    = cell_index(cursor_row_reg, cursor_col_reg);
    assign cursor_cell   = board_bits[{cursor_idx, 1'b0} +: 2];
    assign rd_idx        = cell_index(rd_row, rd_col);
    assign rd_in_range   = (rd_row <= MAX_IDX) && (rd_col <= MAX_IDX);
    assign scan_idx      = cell_index(scan_row, scan_col);
    assign scan_cell     = board_bits[{scan_idx, 1'b0} +: 2];
    assign placer_colour = player_reg ? CELL_WHITE : CELL_BLACK;
    assign accept        = (state_reg == ST_IDLE) && !game_over_reg;

    // Renderer read port: one-cycle latency, off-board addresses read empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cell_reg <= CELL_EMPTY;
        end else begin
            rd_cell_reg <= rd_in_range ? board_bits[{rd_idx, 1'b0} +: 2] : CELL_EMPTY;
        end
    end

    gomoku_win_checker #(
        .BOARD_N (BOARD_N),
        .WIN_LEN (WIN_LEN)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .start     (chk_start),
        .place_row (cursor_row_reg),
        .place_col (cursor_col_reg),
        .colour    (placer_colour),
        .scan_row  (scan_row),
        .scan_col  (scan_col),
        .scan_cell (scan_cell),
        .done      (chk_done),
        .win       (chk_win)
    );

    // Control: button arbitration in IDLE, wait for the checker, then settle
    // the turn or the game result in DONE.
    always_comb begin
        state_next      = state_reg;
        cursor_row_next = cursor_row_reg;
        cursor_col_next = cursor_col_reg;
        player_next     = player_reg;
        move_count_next = move_count_reg;
        game_over_next  = game_over_reg;
        winner_next     = winner_reg;
        win_hit_next    = win_hit_reg;
        wr_en           = 1'b0;
        wr_idx          = cursor_idx;
        wr_val          = placer_colour;
        chk_start       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    // Place wins the cycle even when it lands on a stone and
                    // is discarded; lower-priority pulses are dropped with it.
                    if (btn_place) begin
                        if (cursor_cell == CELL_EMPTY) begin
                            wr_en           = 1'b1;
                            chk_start       = 1'b1;
                            move_count_next = move_count_reg + 8'd1;
                            win_hit_next    = 1'b0;
                            state_next      = ST_CHECK;
                        end
                    end else if (btn_up) begin
                        if (cursor_row_reg != 4'd0) cursor_row_next = cursor_row_reg - 4'd1;
                    end else if (btn_down) begin
                        if (cursor_row_reg != MAX_IDX) cursor_row_next = cursor_row_reg + 4'd1;
                    end else if (btn_left) begin
                        if (cursor_col_reg != 4'd0) cursor_col_next = cursor_col_reg - 4'd1;
                    end else if (btn_right) begin
                        if (cursor_col_reg != MAX_IDX) cursor_col_next = cursor_col_reg + 4'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (chk_done) begin
                    win_hit_next = chk_win;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (win_hit_reg) begin
                    game_over_next = 1'b1;
                    winner_next    = player_reg ? WIN_WHITE : WIN_BLACK;
                end else if (move_count_reg == FULL_COUNT) begin
                    game_over_next = 1'b1;
                    winner_next    = WIN_DRAW;
                end else begin
                    player_next = ~player_reg;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Cursor, turn and game-result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_row_reg <= CENTER;
            cursor_col_reg <= CENTER;
            player_reg     <= 1'b0;
            move_count_reg <= 8'd0;
            game_over_reg  <= 1'b0;
            winner_reg     <= WIN_NONE;
            win_hit_reg    <= 1'b0;
        end else begin
            cursor_row_reg <= cursor_row_next;
            cursor_col_reg <= cursor_col_next;
            player_reg     <= player_next;
            move_count_reg <= move_count_next;
            game_over_reg  <= game_over_next;
            winner_reg     <= winner_next;
            win_hit_reg    <= win_hit_next;
        end
    end

    assign rd_cell    = rd_cell_reg;
    assign cursor_row = cursor_row_reg;
    assign cursor_col = cursor_col_reg;
    assign cur_player = player_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign game_over  = game_over_reg;
    assign winner     = winner_reg;
    assign move_count = move_count_reg;

endmodule

// File: tb/tb_gomoku_board_ctrl.sv
// Directed bench for gomoku_board_ctrl. Read-port expectations go through a
// scoreboard queue (pushed when an address is presented, popped one clock
// later); status outputs are checked against a small board/turn model.
module tb_gomoku_board_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_place = 1'b0;
    logic [3:0] rd_row = 4'd0, rd_col = 4'd0;
    logic [1:0] rd_cell;
    logic [3:0] cursor_row, cursor_col;
    logic       cur_player, busy, game_over;
    logic [1:0] winner;
    logic [7:0] move_count;

    gomoku_board_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_place  (btn_place),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_cell    (rd_cell),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .cur_player (cur_player),
        .busy       (busy),
        .game_over  (game_over),
        .winner     (winner),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [1:0] exp;
    } rd_exp_t;
    rd_exp_t rd_q[$];

    // Reference model
    logic [1:0] model [15][15];
    int         m_row, m_col, m_cnt;
    logic       m_player, m_over;
    logic [1:0] m_winner;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; retire any
    // read presented before this edge.
    task automatic tick();
        rd_exp_t e;
        @(posedge clk);
        #1;
        if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            chk(e.tag, 16'(rd_cell), 16'(e.exp));
        end
    endtask

    task automatic present(input int r, input int c);
        rd_exp_t e;
        rd_row = 4'(r);
        rd_col = 4'(c);
        e.tag  = $sformatf("rd_cell(%0d,%0d)", r, c);
        e.exp  = (r < 15 && c < 15) ? model[r][c] : 2'b00;
        rd_q.push_back(e);
    endtask

    // 0 up, 1 down, 2 left, 3 right
    task automatic pulse(input int which);
        btn_up    = (which == 0);
        btn_down  = (which == 1);
        btn_left  = (which == 2);
        btn_right = (which == 3);
        tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        if (!m_over) begin
            if (which == 0 && m_row > 0)  m_row--;
            if (which == 1 && m_row < 14) m_row++;
            if (which == 2 && m_col > 0)  m_col--;
            if (which == 3 && m_col < 14) m_col++;
        end
    endtask

    task automatic move_to(input int r, input int c);
        for (int k = 0; k < 40 && (m_row != r || m_col != c); k++) begin
            if (m_row > r)      pulse(0);
            else if (m_row < r) pulse(1);
            else if (m_col > c) pulse(2);
            else                pulse(3);
        end
        chk("cursor_row", 16'(cursor_row), 16'(m_row));
        chk("cursor_col", 16'(cursor_col), 16'(m_col));
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_busy"},       16'(busy),       16'(0));
        chk({tag, "_cur_player"}, 16'(cur_player), 16'(m_player));
        chk({tag, "_move_count"}, 16'(move_count), 16'(m_cnt));
        chk({tag, "_game_over"},  16'(game_over),  16'(m_over));
        chk({tag, "_winner"},     16'(winner),     16'(m_winner));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) model[r][c] = 2'b00;
        m_row = 7; m_col = 7; m_cnt = 0;
        m_player = 1'b0; m_over = 1'b0; m_winner = 2'b00;
        chk("rst_cursor_row", 16'(cursor_row), 16'(7));
        chk("rst_cursor_col", 16'(cursor_col), 16'(7));
        chk("rst_rd_cell",    16'(rd_cell),    16'(0));
        check_status("rst");
        rst = 1'b0;
    endtask

    // Place at the cursor; jam holds btn_right and sweeps the read port
    // while the check runs.
    task automatic place_here(input logic exp_win, input logic jam);
        logic ok;
        int   cnt;
        ok = (model[m_row][m_col] == 2'b00) && !m_over;
        btn_place = 1'b1;
        tick();
        btn_place = 1'b0;
        if (ok) begin
            model[m_row][m_col] = m_player ? 2'b10 : 2'b01;
            m_cnt++;
        end
        present(m_row, m_col);
        if (ok) begin
            chk("busy_rise", 16'(busy), 16'(1));
            if (jam) btn_right = 1'b1;
            cnt = 0;
            while (busy !== 1'b0 && cnt < 40) begin
                tick();
                cnt++;
                if (jam) begin
                    chk("jam_cursor", 16'({cursor_row, cursor_col}), 16'({4'(m_row), 4'(m_col)}));
                    present(cnt % 15, (cnt * 4) % 15);
                end
            end
            btn_right = 1'b0;
            chk("check_latency_le_36", 16'(cnt <= 36), 16'(1));
            if (exp_win) begin
                m_over   = 1'b1;
                m_winner = m_player ? 2'b10 : 2'b01;
            end else if (m_cnt == 225) begin
                m_over   = 1'b1;
                m_winner = 2'b11;
            end else begin
                m_player = ~m_player;
            end
        end else begin
            tick();
        end
        if (rd_q.size() != 0) tick();
        check_status("place");
        $display("place (%0d,%0d) accepted=%0d move_count=%0d cur_player=%0d game_over=%0d winner=%0d",
                 m_row, m_col, ok, move_count, cur_player, game_over, winner);
    endtask

    int seq_r [9] = '{3, 0, 4, 0, 6, 0, 7, 0, 5};
    int seq_c [9] = '{3, 0, 4, 2, 6, 4, 7, 6, 5};
    int blk_r[$], blk_c[$], wht_r[$], wht_c[$];

    initial begin
        // Reset, saturating cursor moves, empty board
        do_reset();
        repeat (8) pulse(0);
        repeat (8) pulse(3);
        chk("sat_cursor_row", 16'(cursor_row), 16'(0));
        chk("sat_cursor_col", 16'(cursor_col), 16'(14));
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) begin
                present(r, c);
                tick();
            end
        present(15, 0); tick();
        present(3, 15); tick();
        $display("phase reset/cursor/readback done");

        // Single placement and a repeated placement on the same cell
        move_to(7, 7);
        place_here(1'b0, 1'b0);
        place_here(1'b0, 1'b0);

        // Diagonal win for black, with the check jammed by btn_right
        do_reset();
        for (int i = 0; i < 9; i++) begin
            move_to(seq_r[i], seq_c[i]);
            place_here(i == 8, i == 1);
        end
        btn_place = 1'b1; tick(); btn_place = 1'b0;
        pulse(0);
        pulse(3);
        chk("over_cursor_row", 16'(cursor_row), 16'(m_row));
        chk("over_cursor_col", 16'(cursor_col), 16'(m_col));
        check_status("over");
        present(4, 4); tick();
        present(5, 6); tick();

        // Reset in the middle of a check
        do_reset();
        move_to(2, 9);
        btn_place = 1'b1; tick(); btn_place = 1'b0;
        repeat (5) tick();
        chk("midchk_busy", 16'(busy), 16'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        m_row = 7; m_col = 7;
        chk("abort_cursor_row", 16'(cursor_row), 16'(7));
        chk("abort_cursor_col", 16'(cursor_col), 16'(7));
        check_status("abort");
        present(2, 9); tick();
        tick();
        chk("abort_still_idle", 16'(busy), 16'(0));

        // Full board without five in a row ends in a draw
        do_reset();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) begin
                if (((c + 2 * r) % 4) < 2) begin
                    blk_r.push_back(r); blk_c.push_back(c);
                end else begin
                    wht_r.push_back(r); wht_c.push_back(c);
                end
            end
        for (int i = 0; i < blk_r.size(); i++) begin
            move_to(blk_r[i], blk_c[i]);
            place_here(1'b0, 1'b0);
            if (i < wht_r.size()) begin
                move_to(wht_r[i], wht_c[i]);
                place_here(1'b0, 1'b0);
            end
        end
        chk("draw_winner", 16'(winner), 16'(3));
        present(8, 0);   tick();
        present(7, 15);  tick();
        present(15, 15); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
